// File: rtl/yrv_tick_pkg.sv
// yrv_tick_pkg: shared state type and default sizing for the tick interrupt controller
package yrv_tick_pkg;
  typedef enum logic {IDLE, RUN} tick_state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_DIV   = 6249;
  localparam int DEF_OVR_W = 8;
endpackage

// File: rtl/yrv_sat_counter.sv
// yrv_sat_counter: saturating up-counter with clear that still honours a same-cycle increment
module yrv_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_d, count_q;
  // clear restarts from the current increment; otherwise count up and stick at all-ones
  always_comb count_d = clr ? {{(W-1){1'b0}}, inc} : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/yrv_tick_irq_ctrl.sv
// yrv_tick_irq_ctrl: programmable periodic interrupt source for the MCU ei_req line
module yrv_tick_irq_ctrl
  import yrv_tick_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int OVR_W       = DEF_OVR_W
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             irq_clr,
  input  logic             ovr_clr,
  output logic             ei_req,
  output logic             tick,
  output logic [CNT_W-1:0] cnt_value,
  output logic [OVR_W-1:0] ovr_count,
  output logic             busy
);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  tick_state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, act_d, act_q, shd_d, shd_q;
  logic ei_d, ei_q, tick_d, tick_q, term;
  // next state, period count and divisor pair; the active divisor only changes at a wrap while running
  always_comb begin
    term    = state_q == RUN && cnt_q == act_q;
    state_d = enable ? RUN : IDLE;
    cnt_d   = (state_q == RUN && enable && !term) ? cnt_q + 1'b1 : '0;
    shd_d   = cfg_we ? cfg_div : shd_q;
    act_d   = (state_q == IDLE && cfg_we) ? cfg_div : term ? shd_q : act_q;
  end
  // FSM, period counter and divisor registers
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= DIV_RST;
      shd_q   <= DIV_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
    end
  // pending request latches on terminal count; the level clear beats a simultaneous term
  always_comb begin
    tick_d = term;
    ei_d   = ~irq_clr & (term | ei_q);
  end
  // registered interrupt outputs
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      ei_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      ei_q   <= ei_d;
      tick_q <= tick_d;
    end
  yrv_sat_counter #(.W(OVR_W)) u_ovr (
    .clk    (clk),
    .resetb (resetb),
    .inc    (term & ei_q & ~irq_clr),
    .clr    (ovr_clr),
    .count  (ovr_count)
  );
  assign ei_req    = ei_q;
  assign tick      = tick_q;
  assign cnt_value = cnt_q;
  assign busy      = state_q == RUN;
endmodule

// File: tb/tb_yrv_tick_irq_ctrl.sv
// tb_yrv_tick_irq_ctrl: directed bench with a period-based reference model checked every cycle
module tb_yrv_tick_irq_ctrl;
  logic        clk = 1'b0;
  logic        resetb = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        irq_clr = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        ei_req, tick, busy;
  logic [15:0] cnt_value;
  logic [7:0]  ovr_count;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  yrv_tick_irq_ctrl dut (
    .clk       (clk),
    .resetb    (resetb),
    .enable    (enable),
    .cfg_we    (cfg_we),
    .cfg_div   (cfg_div),
    .irq_clr   (irq_clr),
    .ovr_clr   (ovr_clr),
    .ei_req    (ei_req),
    .tick      (tick),
    .cnt_value (cnt_value),
    .ovr_count (ovr_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: a period of m_per cycles, position m_pos within it, next period length queued in m_next.
  int m_pos = 0;
  int m_per = 6250;
  int m_next = 6250;
  int m_ovr = 0;
  bit m_run = 1'b0;
  bit m_ei = 1'b0;
  bit m_tick = 1'b0;
  logic m_term, m_lost;
  assign m_term = m_run && (m_pos == m_per - 1);
  assign m_lost = m_term && m_ei && !irq_clr;

  always @(posedge clk or negedge resetb)
    if (!resetb) begin
      m_pos  <= 0;
      m_per  <= 6250;
      m_next <= 6250;
      m_ovr  <= 0;
      m_run  <= 1'b0;
      m_ei   <= 1'b0;
      m_tick <= 1'b0;
    end else begin
      m_tick <= m_term;
      m_ei   <= !irq_clr && (m_term || m_ei);
      m_ovr  <= ovr_clr ? int'(m_lost) : (m_lost && m_ovr < 255) ? m_ovr + 1 : m_ovr;
      m_run  <= enable;
      m_pos  <= (m_run && enable && !m_term) ? m_pos + 1 : 0;
      m_per  <= (!m_run && cfg_we) ? int'(cfg_div) + 1 : m_term ? m_next : m_per;
      m_next <= cfg_we ? int'(cfg_div) + 1 : m_next;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk)
    if (chk_en) begin
      chk("model_cnt", 32'(cnt_value), 32'(m_pos));
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_ei", 32'(ei_req), 32'(m_ei));
      chk("model_busy", 32'(busy), 32'(m_run));
      chk("model_ovr", 32'(ovr_count), 32'(m_ovr));
    end

  initial begin
    #1 resetb = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_ei", 32'(ei_req), 0);
    chk("rst_busy", 32'(busy), 0);
    step(3);
    resetb = 1'b1;
    step(1);
    enable = 1'b1;
    step(1);
    chk("run_busy", 32'(busy), 1);
    chk("run_cnt0", 32'(cnt_value), 0);
    step(6249);
    chk("pre_term_cnt", 32'(cnt_value), 6249);
    chk("pre_term_ei", 32'(ei_req), 0);
    step(1);
    chk("first_tick", 32'(tick), 1);
    chk("first_ei", 32'(ei_req), 1);
    chk("wrap_cnt", 32'(cnt_value), 0);
    step(1);
    chk("tick_pulse", 32'(tick), 0);
    step(6249);
    chk("second_tick", 32'(tick), 1);
    chk("ovr_one", 32'(ovr_count), 1);
    step(6250);
    chk("ovr_two", 32'(ovr_count), 2);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(ovr_count), 0);
    step(2999);
    chk("cnt_3000", 32'(cnt_value), 3000);
    enable = 1'b0;
    step(1);
    chk("drop_cnt", 32'(cnt_value), 0);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_ei_kept", 32'(ei_req), 1);
    step(5);
    chk("idle_ei_kept", 32'(ei_req), 1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("idle_ei_clr", 32'(ei_req), 0);
    enable = 1'b1;
    step(101);
    chk("cnt_100", 32'(cnt_value), 100);
    cfg_we = 1'b1;
    cfg_div = 16'd9;
    step(1);
    cfg_we = 1'b0;
    step(6148);
    chk("no_mid_period", 32'(cnt_value), 6249);
    step(1);
    chk("old_period_tick", 32'(tick), 1);
    step(10);
    chk("div9_tick", 32'(tick), 1);
    chk("div9_ovr", 32'(ovr_count), 1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("run_ei_clr", 32'(ei_req), 0);
    step(8);
    chk("cnt_9", 32'(cnt_value), 9);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("clr_vs_term_tick", 32'(tick), 1);
    chk("clr_vs_term_ei", 32'(ei_req), 0);
    chk("clr_vs_term_ovr", 32'(ovr_count), 1);
    step(9);
    cfg_we = 1'b1;
    cfg_div = 16'd4;
    step(1);
    cfg_we = 1'b0;
    chk("we_on_term_tick", 32'(tick), 1);
    step(9);
    chk("we_on_term_old", 32'(cnt_value), 9);
    step(1);
    chk("we_on_term_wrap", 32'(tick), 1);
    step(5);
    chk("div4_tick", 32'(tick), 1);
    chk("div4_ovr3", 32'(ovr_count), 3);
    step(5);
    chk("div4_ovr4", 32'(ovr_count), 4);
    cfg_we = 1'b1;
    cfg_div = 16'd4100;
    step(1);
    cfg_we = 1'b0;
    step(4);
    chk("ovr_five", 32'(ovr_count), 5);
    cfg_we = 1'b1;
    cfg_div = 16'd7;
    step(1);
    cfg_we = 1'b0;
    step(3999);
    chk("cnt_4000", 32'(cnt_value), 4000);
    chk("pre_rst_ei", 32'(ei_req), 1);
    #1 resetb = 1'b0;
    #1;
    chk("async_cnt", 32'(cnt_value), 0);
    chk("async_ei", 32'(ei_req), 0);
    chk("async_ovr", 32'(ovr_count), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_tick", 32'(tick), 0);
    step(2);
    resetb = 1'b1;
    step(1);
    chk("post_rst_busy", 32'(busy), 1);
    step(6249);
    chk("post_rst_div", 32'(cnt_value), 6249);
    step(1);
    chk("post_rst_tick", 32'(tick), 1);
    enable = 1'b0;
    step(1);
    cfg_we = 1'b1;
    cfg_div = 16'd0;
    enable = 1'b1;
    step(1);
    cfg_we = 1'b0;
    chk("idle_load_busy", 32'(busy), 1);
    step(300);
    chk("div0_tick", 32'(tick), 1);
    chk("sat_255", 32'(ovr_count), 255);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    chk("clr_with_ovr", 32'(ovr_count), 1);
    step(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
